// File: rtl/data_ram_arbiter_if.sv
// Single-master req/ack port into the data_ram arbiter.
// The master holds req and all fields stable until it sees a one-cycle ack.
interface data_ram_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int SW = 4
);
    logic          req;
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, sel, addr, wdata, input ack, rdata);
    modport slave  (input req, we, sel, addr, wdata, output ack, rdata);
endinterface

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter for the single data_ram port; req at t -> RAM access t+1 -> ack t+2.
// Losing master holds req until granted; requests are only sampled in IDLE.
module data_ram_arbiter #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int SW        = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    data_ram_arbiter_if.slave m0,
    data_ram_arbiter_if.slave m1,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [SW-1:0]     ram_sel,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_data_o,
    input  logic [DW-1:0]     ram_data_i,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t        state;
    logic          last_grant;
    logic          owner;
    logic          we_q;
    logic [SW-1:0] sel_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          grant;

    // Winner only feeds registers, so req never reaches ram_* or ack combinationally.
    always_comb begin
        grant = 1'b0;
        if (m0.req && m1.req) begin
            grant = (PRIO_MODE == 1) ? 1'b0 : ~last_grant;
        end else if (m1.req) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            ram_ce <= 1'b0;
            ram_we <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0.req || m1.req) begin
                        owner   <= grant;
                        we_q    <= grant ? m1.we    : m0.we;
                        sel_q   <= grant ? m1.sel   : m0.sel;
                        addr_q  <= grant ? m1.addr  : m0.addr;
                        wdata_q <= grant ? m1.wdata : m0.wdata;
                        ram_ce  <= 1'b1;
                        ram_we  <= grant ? m1.we : m0.we;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q <= we_q ? '0 : ram_data_i;
                    ack0_q  <= ~owner;
                    ack1_q  <= owner;
                    state   <= RESP;
                end
                RESP: begin
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ram_sel    = sel_q;
    assign ram_addr   = addr_q;
    assign ram_data_o = wdata_q;
    assign busy       = (state != IDLE);

    assign m0.ack   = ack0_q;
    assign m1.ack   = ack1_q;
    assign m0.rdata = ack0_q ? rdata_q : '0;
    assign m1.rdata = ack1_q ? rdata_q : '0;
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: round-robin instance with a byte-write RAM model,
// fixed-priority instance with an address-derived read pattern.
`timescale 1ns/1ps
module tb_data_ram_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_ram_arbiter_if a0 ();
    data_ram_arbiter_if a1 ();
    data_ram_arbiter_if b0 ();
    data_ram_arbiter_if b1 ();

    logic        ram0_ce, ram0_we, busy0;
    logic [3:0]  ram0_sel;
    logic [31:0] ram0_addr, ram0_wdata, ram0_rdata;
    logic        ram1_ce, ram1_we, busy1;
    logic [3:0]  ram1_sel;
    logic [31:0] ram1_addr, ram1_wdata, ram1_rdata;

    data_ram_arbiter #(.PRIO_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .m0(a0), .m1(a1),
        .ram_ce(ram0_ce), .ram_we(ram0_we), .ram_sel(ram0_sel), .ram_addr(ram0_addr),
        .ram_data_o(ram0_wdata), .ram_data_i(ram0_rdata), .busy(busy0)
    );

    data_ram_arbiter #(.PRIO_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .m0(b0), .m1(b1),
        .ram_ce(ram1_ce), .ram_we(ram1_we), .ram_sel(ram1_sel), .ram_addr(ram1_addr),
        .ram_data_o(ram1_wdata), .ram_data_i(ram1_rdata), .busy(busy1)
    );

    logic [31:0] mem [0:63];
    assign ram0_rdata = mem[ram0_addr[7:2]];
    always @(posedge clk) begin
        if (ram0_ce && ram0_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram0_sel[b]) mem[ram0_addr[7:2]][8*b +: 8] <= ram0_wdata[8*b +: 8];
            end
        end
    end
    assign ram1_rdata = ram1_addr ^ 32'hA5A5_0000;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int last_ce0 = 0;
    int last_ack0 = 0;
    logic last_we0 = 1'b0;
    logic [31:0] last_addr0 = '0;
    logic prev_ce0 = 1'b0;
    int ack_cnt [4];
    logic [31:0] exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];
    int ord_q0[$], ord_q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int m, input logic r, input logic w, input logic [3:0] s,
                         input logic [31:0] ad, input logic [31:0] wd);
        case (m)
            0: begin a0.req = r; a0.we = w; a0.sel = s; a0.addr = ad; a0.wdata = wd; end
            1: begin a1.req = r; a1.we = w; a1.sel = s; a1.addr = ad; a1.wdata = wd; end
            2: begin b0.req = r; b0.we = w; b0.sel = s; b0.addr = ad; b0.wdata = wd; end
            default: begin b1.req = r; b1.we = w; b1.sel = s; b1.addr = ad; b1.wdata = wd; end
        endcase
    endtask

    function automatic logic ack_of(input int m);
        case (m)
            0: return a0.ack;
            1: return a1.ack;
            2: return b0.ack;
            default: return b1.ack;
        endcase
    endfunction

    // Issue one transaction: expected read data goes to the master's queue, then wait for ack.
    task automatic do_m(input int m, input logic w, input logic [3:0] s, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [31:0] exp_rd, output int lat);
        case (m)
            0: exp_q0.push_back(exp_rd);
            1: exp_q1.push_back(exp_rd);
            2: exp_q2.push_back(exp_rd);
            default: exp_q3.push_back(exp_rd);
        endcase
        drive(m, 1'b1, w, s, ad, wd);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack_of(m)) break;
        end
        if (!ack_of(m)) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout master=%0d actual=no_ack required=ack", m);
        end
        drive(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
    endtask

    task automatic mon(input int m, input logic ack, input logic [31:0] rd);
        logic [31:0] e;
        int o;
        if (!ack) begin
            chk($sformatf("idle_rdata_m%0d", m), rd, 32'h0);
        end else begin
            ack_cnt[m]++;
            e = 32'hFFFF_FFFF;
            o = -1;
            case (m)
                0: if (exp_q0.size() > 0) e = exp_q0.pop_front();
                1: if (exp_q1.size() > 0) e = exp_q1.pop_front();
                2: if (exp_q2.size() > 0) e = exp_q2.pop_front();
                default: if (exp_q3.size() > 0) e = exp_q3.pop_front();
            endcase
            if (m < 2) begin
                if (ord_q0.size() > 0) o = ord_q0.pop_front();
            end else begin
                if (ord_q1.size() > 0) o = ord_q1.pop_front();
            end
            chk($sformatf("ack_rdata_m%0d", m), rd, e);
            chk($sformatf("grant_order_m%0d", m), 32'(m % 2), 32'(o));
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            mon(0, a0.ack, a0.rdata);
            mon(1, a1.ack, a1.rdata);
            mon(2, b0.ack, b0.rdata);
            mon(3, b1.ack, b1.rdata);
            if (a0.ack || a1.ack) last_ack0 = ncyc;
            if (ram0_ce) begin
                chk("ce_single_cycle", {31'b0, prev_ce0}, 32'h0);
                last_ce0 = ncyc;
                last_we0 = ram0_we;
                last_addr0 = ram0_addr;
            end
            prev_ce0 = ram0_ce;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int l, la, lb, base;
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b0;

        // Reset held with m0 requesting: everything quiet.
        drive(0, 1'b1, 1'b1, 4'hF, 32'h40, 32'h0BAD_CAFE);
        repeat (3) @(negedge clk);
        chk("rst_ram_ce", {31'b0, ram0_ce}, 32'h0);
        chk("rst_ram_we", {31'b0, ram0_we}, 32'h0);
        chk("rst_busy", {31'b0, busy0}, 32'h0);
        chk("rst_ack0", {31'b0, a0.ack}, 32'h0);
        chk("rst_rdata0", a0.rdata, 32'h0);
        chk("rst_ram_addr", ram0_addr, 32'h0);
        chk("rst_ram_sel", {28'b0, ram0_sel}, 32'h0);
        chk("rst_ram_data_o", ram0_wdata, 32'h0);
        chk("rst_busy1", {31'b0, busy1}, 32'h0);
        rst = 1'b1;
        ord_q0.push_back(0);
        do_m(0, 1'b1, 4'hF, 32'h40, 32'h0BAD_CAFE, 32'h0, l);
        chk("post_rst_lat", 32'(l), 32'd2);
        chk("post_rst_ce_before_ack", 32'(last_ce0), 32'(last_ack0 - 1));

        // Master 0 write then read.
        ord_q0.push_back(0);
        do_m(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, l);
        chk("wr_we", {31'b0, last_we0}, 32'h1);
        chk("wr_addr", last_addr0, 32'h10);
        @(negedge clk);
        ord_q0.push_back(0);
        do_m(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, l);
        chk("rd_lat", 32'(l), 32'd2);
        chk("rd_we", {31'b0, last_we0}, 32'h0);

        // Fresh reset so master 0 wins the first tie.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ord_q0.push_back(0);
        ord_q0.push_back(1);
        fork
            do_m(0, 1'b1, 4'hF, 32'h30, 32'h3030_3030, 32'h0, la);
            do_m(1, 1'b1, 4'hF, 32'h34, 32'h3434_3434, 32'h0, lb);
        join
        chk("tie_m0_lat", 32'(la), 32'd2);
        chk("tie_m1_lat", 32'(lb), 32'd5);

        // Both held continuously: strict alternation, m0 first (last owner was m1).
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            ord_q0.push_back(0);
            ord_q0.push_back(1);
        end
        fork
            begin
                int lx;
                for (int k = 0; k < 3; k++) begin
                    do_m(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, lx);
                    chk($sformatf("rr_m0_lat%0d", k), 32'(lx), (k == 0) ? 32'd2 : 32'd6);
                end
            end
            begin
                int ly;
                for (int k = 0; k < 3; k++) begin
                    do_m(1, 1'b1, 4'hF, 32'h50 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 32'h0, ly);
                    chk($sformatf("rr_m1_lat%0d", k), 32'(ly), (k == 0) ? 32'd5 : 32'd6);
                end
            end
        join

        // Byte write merge from master 1.
        @(negedge clk);
        repeat (3) ord_q0.push_back(1);
        do_m(1, 1'b1, 4'hF, 32'h20, 32'h1122_3344, 32'h0, l);
        do_m(1, 1'b1, 4'b0100, 32'h20, 32'h00AB_0000, 32'h0, l);
        do_m(1, 1'b0, 4'hF, 32'h20, 32'h0, 32'h11AB_3344, l);
        chk("byte_rd_lat", 32'(l), 32'd3);

        // Fixed priority: m0 starves m1 until it drops req.
        @(negedge clk);
        ord_q1.push_back(0);
        ord_q1.push_back(0);
        ord_q1.push_back(0);
        ord_q1.push_back(1);
        fork
            begin
                int lx;
                for (int k = 0; k < 3; k++) begin
                    do_m(2, 1'b0, 4'hF, 32'h100 + 32'(4 * k), 32'h0, 32'hA5A5_0100 + 32'(4 * k), lx);
                    chk($sformatf("fp_m0_lat%0d", k), 32'(lx), (k == 0) ? 32'd2 : 32'd3);
                end
            end
            begin
                int ly;
                do_m(3, 1'b0, 4'hF, 32'h200, 32'h0, 32'hA5A5_0200, ly);
                chk("fp_m1_lat", 32'(ly), 32'd11);
            end
        join

        // Reset during ACCESS of an m1 read: aborted, never acked.
        @(negedge clk);
        base = ack_cnt[1];
        drive(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        @(negedge clk);
        chk("abort_ce_in_access", {31'b0, ram0_ce}, 32'h1);
        rst = 1'b0;
        #1;
        chk("abort_ce_async", {31'b0, ram0_ce}, 32'h0);
        chk("abort_busy_async", {31'b0, busy0}, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_ack", 32'(ack_cnt[1]), 32'(base));
        chk("abort_idle", {31'b0, busy0}, 32'h0);

        chk("exp_queues_drained",
            32'(exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size()), 32'h0);
        chk("order_queues_drained", 32'(ord_q0.size() + ord_q1.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
